ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to a keyboard. It runs the open-drain request-to-send sequence, shifts 8 data bits, odd parity and stop on device-generated clock edges, and checks the device acknowledge. It sits beside the PS/2 receive path on the same ps2c/ps2d pins. While `busy` is high, the receive path must ignore line activity.

## Interface
- INHIBIT_CYCLES, 2700: clock_27mhz cycles that ps2c is held low before the start bit (100 us).
- TIMEOUT_CYCLES, 405000: maximum gap between device clock falling edges, and maximum wait for idle after ack (15 ms).
- clock_27mhz  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high; returns the block to IDLE and releases both lines.
- tx_data  in  8  command byte, sampled when tx_valid & tx_ready.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE.
- ps2c  in  1  PS/2 clock pin level (asynchronous).
- ps2d  in  1  PS/2 data pin level (asynchronous).
- ps2c_oe  out  1  1 = drive the clock pin low; 0 = release it.
- ps2d_oe  out  1  1 = drive the data pin low; 0 = release it.
- busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse: byte sent and acknowledged.
- tx_error  out  1  one-cycle pulse: missing ack or timeout.

## Operation
- **Input synchronisation**
  - ps2c passes through a 3-flop synchroniser. Falling edge: fall = c_s[2] & ~c_s[1].
  - ps2d passes through a 2-flop synchroniser; d_s[1] is the sampled data value.
- **Frame**: shift register {1 (stop), parity, tx_data[7:0]}, loaded on accept, sent LSB first. parity = ~^tx_data (odd).
- **States**
  - IDLE: tx_ready=1, both oe=0. On tx_valid, load the frame, clear counters, go to INHIBIT.
  - INHIBIT: ps2c_oe=1. After INHIBIT_CYCLES cycles go to START.
  - START: ps2c_oe=1 and ps2d_oe=1 for exactly 1 cycle, then go to SEND.
  - SEND: ps2c_oe=0.
    - ps2d_oe starts at 1 (start bit 0).
    - On each fall, bit counter k increments (1..10).
    - For k=1..9, ps2d_oe = ~frame[k-1] (data bits, then parity).
    - At k=10, ps2d_oe=0 (stop bit 1, line released); go to ACK.
  - ACK: both oe=0. On the next fall, sample d_s[1].
    - 0: go to WAIT_IDLE.
    - 1: pulse tx_error, go to IDLE.
  - WAIT_IDLE: when c_s[1]=1 and d_s[1]=1, pulse tx_done and go to IDLE.
- **Timeout**
  - The counter clears on entry to SEND and on every fall. It runs in SEND, ACK and WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES: pulse tx_error, release both lines, go to IDLE.
- **Flow control**: tx_valid outside IDLE is ignored (no queue). The caller holds tx_valid until it sees tx_ready.
- Falls that occur in IDLE, INHIBIT or START are ignored.
- **Reset**, including mid-frame: on the next edge state=IDLE, ps2c_oe=0, ps2d_oe=0, busy=0, tx_done=0, tx_error=0, tx_ready=1, counters cleared.

## Timing
- **Accept**: in the cycle where tx_valid & tx_ready, the next edge sets ps2c_oe=1, busy=1 and tx_ready=0.
- ps2c_oe stays high for INHIBIT_CYCLES+1 cycles: INHIBIT plus the 1 START cycle.
- ps2d_oe rises in the START cycle and stays high until the first fall changes it.
- Each fall registers its ps2d_oe update 3 cycles after the pin edge: 2 synchroniser cycles plus 1 register. The line therefore changes while the device holds the clock low, well inside the ~30 us low phase.
- tx_done and tx_error are registered, mutually exclusive, and last exactly 1 cycle. tx_ready=1 in the cycle after either pulse.
- All outputs are registered.

## Test plan
- **0xED with a compliant device model** (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200; device clocks at a 40-cycle period, samples on rise, acks low on edge 11):
  - ps2c_oe is high for 21 cycles.
  - Device captures start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once; tx_error stays 0.
- **0xF4**: device captures parity 0; tx_done pulses.
- **No ack** (device leaves data high on edge 11): tx_error pulses, no tx_done, returns to IDLE with both oe=0.
- **Device never clocks after START**: tx_error exactly 200 cycles after SEND entry, ps2d_oe returns to 0, and busy is 0 on the following cycle.
- **Reset after falling edge 5**: next cycle both oe=0, tx_ready=1. A following 0xFF transfer completes with tx_done.
- **tx_valid held during a transfer with a different byte**: ignored; only the first byte appears on the wire. A second byte sends after tx_ready returns.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: request-to-send, 11-bit frame clocked
// by the device, acknowledge check and a line-activity timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2700,
    parameter int TIMEOUT_CYCLES = 405000
) (
    input  logic       clock_27mhz,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);
    localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INHIBIT   = 3'd1;
    localparam logic [2:0] START     = 3'd2;
    localparam logic [2:0] SEND      = 3'd3;
    localparam logic [2:0] ACK       = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [2:0]    c_s_q;
    logic [1:0]    d_s_q;
    logic [9:0]    frame_q, frame_d;
    logic [3:0]    k_q, k_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          c_oe_q, c_oe_d, d_oe_q, d_oe_d;
    logic          done_q, done_d, err_q, err_d;
    logic          busy_q, ready_q;
    logic          fall, timeout;

    assign fall    = c_s_q[2] & ~c_s_q[1];
    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        c_oe_d  = c_oe_q;
        d_oe_d  = d_oe_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                c_oe_d = 1'b0;
                d_oe_d = 1'b0;
                if (tx_valid) begin
                    frame_d = {1'b1, ~^tx_data, tx_data};
                    k_d     = 4'd0;
                    cnt_d   = '0;
                    c_oe_d  = 1'b1;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                    d_oe_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = START;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            START: begin
                // Releasing the clock with data held low is the start bit.
                c_oe_d  = 1'b0;
                cnt_d   = '0;
                k_d     = 4'd0;
                state_d = SEND;
            end
            SEND: begin
                if (fall) begin
                    k_d   = k_q + 4'd1;
                    cnt_d = '0;
                    if (k_q == 4'd9) begin
                        d_oe_d  = 1'b0;
                        state_d = ACK;
                    end else begin
                        d_oe_d = ~frame_q[k_q];
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    c_oe_d  = 1'b0;
                    d_oe_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACK: begin
                if (fall) begin
                    cnt_d = '0;
                    if (d_s_q[1]) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_IDLE: begin
                if (c_s_q[1] && d_s_q[1]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (fall) begin
                    cnt_d = '0;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                c_oe_d  = 1'b0;
                d_oe_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            state_q <= IDLE;
            c_s_q   <= 3'b111;
            d_s_q   <= 2'b11;
            frame_q <= '0;
            k_q     <= 4'd0;
            cnt_q   <= '0;
            c_oe_q  <= 1'b0;
            d_oe_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            c_s_q   <= {c_s_q[1:0], ps2c};
            d_s_q   <= {d_s_q[0], ps2d};
            frame_q <= frame_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            c_oe_q  <= c_oe_d;
            d_oe_q  <= d_oe_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= (state_d != IDLE);
            ready_q <= (state_d == IDLE);
        end
    end

    assign tx_ready = ready_q;
    assign busy     = busy_q;
    assign ps2c_oe  = c_oe_q;
    assign ps2d_oe  = d_oe_q;
    assign tx_done  = done_q;
    assign tx_error = err_q;
endmodule
